piso_shift_reg: RTL and testbench

//  Parallel-in/serial-out shift register: the transmit end for the 4-bit serial-in shift registers.

---
 rtl/piso_shift_reg_if.sv | 30 +++
 rtl/piso_shift_reg.sv | 70 +++++++
 tb/tb_piso_shift_reg.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_shift_reg_if.sv
// Parallel-side handshake and serial-side output bundle for piso_shift_reg.
// The master drives Load/Din and observes the serial stream; the slave is the shifter.
interface piso_shift_reg_if #(
  parameter int unsigned WIDTH = 4
);
  logic             Load;
  logic [WIDTH-1:0] Din;
  logic             Ready;
  logic             Sout;
  logic             Sout_valid;
  logic             Done;

  modport master (
    output Load,
    output Din,
    input  Ready,
    input  Sout,
    input  Sout_valid,
    input  Done
  );

  modport slave (
    input  Load,
    input  Din,
    output Ready,
    output Sout,
    output Sout_valid,
    output Done
  );
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register, MSB first, with a valid/ready word handshake.
// A word accepted at edge k has its MSB on Sout in the following cycle; a new word may be
// accepted during the final-bit cycle so back-to-back words stream without a gap.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit after the LSB.
module piso_shift_reg #(
  parameter int unsigned WIDTH = 4
) (
  input logic             Clk,
  input logic             Rst,
  piso_shift_reg_if.slave bus
);

`ifdef PISO_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif
  localparam int unsigned    CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(NBITS - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q;
  logic [NBITS-1:0] shreg_q;
  logic [CntW-1:0]  cnt_q;
  logic [NBITS-1:0] load_word;
  logic             last_bit;
  logic             accept;

  assign last_bit = (state_q == StShift) && (cnt_q == LastCnt);

  // Parity is folded into the shift register so it falls out after the LSB for free.
`ifdef PISO_PARITY_EN
  assign load_word = {bus.Din, ^bus.Din};
`else
  assign load_word = bus.Din;
`endif

  // Ready depends only on registered state, never on Load.
  assign bus.Ready = (state_q == StIdle) || last_bit;
  assign accept    = bus.Load && bus.Ready;

  // State, shift register and bit counter; reset or abort returns everything to idle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      state_q <= StShift;
      shreg_q <= load_word;
      cnt_q   <= '0;
    end else if (last_bit) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (state_q == StShift) begin
      shreg_q <= {shreg_q[NBITS-2:0], 1'b0};
      cnt_q   <= cnt_q + CntW'(1);
    end
  end

  // Serial outputs decode registered state only, so Din/Load cannot glitch them.
  always_comb begin
    bus.Sout       = (state_q == StShift) && shreg_q[NBITS-1];
    bus.Sout_valid = (state_q == StShift);
    bus.Done       = last_bit;
  end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Self-checking bench for piso_shift_reg (WIDTH=4), scoreboard-based serial output checking.
module tb_piso_shift_reg;
  localparam int unsigned W = 4;
`ifdef PISO_PARITY_EN
  localparam int unsigned NBITS = W + 1;
`else
  localparam int unsigned NBITS = W;
`endif

  typedef struct packed {
    logic sout;
    logic done;
  } exp_t;

  logic Clk;
  logic Rst;
  piso_shift_reg_if #(.WIDTH(W)) bus ();

  piso_shift_reg #(.WIDTH(W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [NBITS-1:0] rx = '0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Expected receiver contents after a whole word has been shifted in.
  function automatic logic [NBITS-1:0] exp_rx(input logic [W-1:0] w);
`ifdef PISO_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  function automatic void push_word(input logic [W-1:0] w);
    exp_t e;
    for (int i = W - 1; i >= 0; i--) begin
      e.sout = w[i];
`ifdef PISO_PARITY_EN
      e.done = 1'b0;
`else
      e.done = (i == 0);
`endif
      sb.push_back(e);
    end
`ifdef PISO_PARITY_EN
    e.sout = ^w;
    e.done = 1'b1;
    sb.push_back(e);
`endif
  endfunction

  // Scoreboard monitor plus serial-in receiver model (Q[0] <= D, upward shift).
  always @(negedge Clk) begin
    if (Rst === 1'b0) begin
      if (bus.Sout_valid === 1'b1) begin
        exp_t e;
        rx = {rx[NBITS-2:0], bus.Sout};
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_bit: got Sout=%b Done=%b, expected no valid bit", bus.Sout,
                   bus.Done);
        end else begin
          e = sb.pop_front();
          if (bus.Sout !== e.sout || bus.Done !== e.done) begin
            errors++;
            $display("FAIL serial_bit: got Sout=%b Done=%b, expected Sout=%b Done=%b",
                     bus.Sout, bus.Done, e.sout, e.done);
          end
        end
      end else begin
        checks++;
        if (bus.Sout !== 1'b0 || bus.Done !== 1'b0 || bus.Sout_valid !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs: got Sout=%b Done=%b Sout_valid=%b, expected 0 0 0",
                   bus.Sout, bus.Done, bus.Sout_valid);
        end
      end
    end
  end

  // Waits (bounded) for Ready at a negedge, then presents one word for the next edge.
  task automatic send_word(input logic [W-1:0] w);
    bit got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      if (bus.Ready === 1'b1) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ready_timeout: got Ready=%b, expected 1", bus.Ready);
    end
    bus.Load = 1'b1;
    bus.Din  = w;
    push_word(w);
    @(posedge Clk);
    #1;
    bus.Load = 1'b0;
    bus.Din  = W'($urandom);
  endtask

  // Bounded wait for the stream to finish, then check idle and receiver contents.
  task automatic drain(input string name, input logic [NBITS-1:0] want_rx);
    for (int i = 0; i < 4 * NBITS; i++) begin
      @(negedge Clk);
      if (sb.size() == 0 && bus.Sout_valid === 1'b0) break;
    end
    checks++;
    if (sb.size() != 0 || bus.Sout_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: got %0d bits pending Sout_valid=%b, expected 0 and 0", name,
               sb.size(), bus.Sout_valid);
      sb.delete();
    end
    checks++;
    if (rx !== want_rx) begin
      errors++;
      $display("FAIL %s_rx: got Q=%b, expected %b", name, rx, want_rx);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    bus.Load = 1'b0;
    bus.Din = '0;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    @(negedge Clk);
    checks++;
    if (bus.Ready !== 1'b1 || bus.Sout !== 1'b0 || bus.Sout_valid !== 1'b0 ||
        bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got Ready=%b Sout=%b Sout_valid=%b Done=%b, expected 1 0 0 0",
               bus.Ready, bus.Sout, bus.Sout_valid, bus.Done);
    end
  endtask

  task automatic test_single();
    send_word(4'b1011);
    drain("single", exp_rx(4'b1011));
  endtask

  task automatic test_back_to_back();
    @(negedge Clk);
    bus.Load = 1'b1;
    bus.Din  = 4'b1011;
    push_word(4'b1011);
    @(posedge Clk);
    #1;
    bus.Load = 1'b0;
    for (int j = 0; j < 2 * NBITS; j++) begin
      @(negedge Clk);
      checks++;
      if (bus.Sout_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_contiguous: bit %0d got Sout_valid=%b, expected 1", j,
                 bus.Sout_valid);
      end
      if (j == NBITS - 1) begin
        checks++;
        if (bus.Ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready_on_last: got Ready=%b, expected 1", bus.Ready);
        end
        bus.Load = 1'b1;
        bus.Din  = 4'b0110;
        push_word(4'b0110);
      end else begin
        bus.Load = 1'b0;
      end
    end
    drain("b2b", exp_rx(4'b0110));
  endtask

  task automatic test_ignore_busy();
    send_word(4'b1100);
    for (int j = 0; j < NBITS; j++) begin
      @(negedge Clk);
      if (j == 1 || j == 2) begin
        checks++;
        if (bus.Ready !== 1'b0) begin
          errors++;
          $display("FAIL busy_ready: bit %0d got Ready=%b, expected 0", j, bus.Ready);
        end
        bus.Load = 1'b1;
        bus.Din  = 4'b0011;
      end else begin
        bus.Load = 1'b0;
      end
    end
    bus.Load = 1'b0;
    drain("ignore", exp_rx(4'b1100));
  endtask

  task automatic test_reset_abort();
    send_word(4'b1111);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    sb.delete();
    @(negedge Clk);
    checks++;
    if (bus.Sout_valid !== 1'b0 || bus.Ready !== 1'b1 || bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: got Sout_valid=%b Ready=%b Done=%b, expected 0 1 0",
               bus.Sout_valid, bus.Ready, bus.Done);
    end
    send_word(4'b0001);
    drain("after_abort", exp_rx(4'b0001));
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    for (int k = 0; k < 6; k++) begin
      w = W'($urandom);
      send_word(w);
      if ($urandom_range(0, 1) == 1) drain("random", exp_rx(w));
    end
    drain("random_end", exp_rx(w));
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    send_word(4'b1011);
    drain("parity_1011", 5'b10111);
    send_word(4'b1001);
    drain("parity_1001", 5'b10010);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_reset_abort();
    test_random();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    repeat (2) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
